// File: rtl/dmux8way16_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmux8way16_pkg
//  Purpose  : Shared types and constants for the registered 1-to-8 word
//             distributor (lane index, data word, lane mask, select decode).
//  Revision : 1.0  initial release
// ============================================================================
package dmux8way16_pkg;

    localparam int WIDTH = 16;
    localparam int LANES = 8;

    typedef logic [2:0]       lane_idx_t;
    typedef logic [WIDTH-1:0] word_t;
    typedef logic [LANES-1:0] lane_mask_t;

    // One-hot lane mask for a lane index (bit 0 is lane a)
    function automatic lane_mask_t lane_onehot(input lane_idx_t idx);
        lane_mask_t mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage : dmux8way16_pkg
`default_nettype wire

// File: rtl/dmux_lane.sv
`default_nettype none
// ============================================================================
//  Module   : dmux_lane
//  Purpose  : One single-entry output lane: holding register, full flag,
//             load / drain / same-cycle refill, and a "free" indication.
//  Revision : 1.0  initial release
// ============================================================================
module dmux_lane
    import dmux8way16_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  word_t din,
    input  logic  drain_ready,
    output word_t data,
    output logic  full,
    output logic  free
);

    word_t r_data;
    logic  r_full;

    // The lane can take a word when empty, or when the held word leaves this cycle
    assign free = ~r_full | drain_ready;
    assign data = r_data;
    assign full = r_full;

    // Holding register: a load takes priority over a drain so a refill keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else begin
            if (load) begin
                r_data <= din;
                r_full <= 1'b1;
            end else if (r_full && drain_ready) begin
                r_full <= 1'b0;
            end
        end
    end

endmodule : dmux_lane
`default_nettype wire

// File: rtl/dmux8way16_reg.sv
`default_nettype none
// ============================================================================
//  Module   : dmux8way16_reg
//  Purpose  : Registered 1-to-8 distributor for 16-bit words. A word accepted
//             on the valid/ready input is steered by sel into one of eight
//             single-entry lanes, each with its own valid/ready handshake.
//             Optional broadcast (all lanes at once) when the macro
//             DMUX8WAY16_BCAST_EN is defined; otherwise unicast only.
//  Revision : 1.0  initial release
// ============================================================================
module dmux8way16_reg #(
    parameter int WIDTH = 16,
    parameter int LANES = 8
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DMUX8WAY16_BCAST_EN
    input  logic             bcast,
`endif
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic [LANES-1:0] out_valid,
    input  logic [LANES-1:0] out_ready,
    output logic [15:0]      xfer_count
);

    import dmux8way16_pkg::*;

    logic [LANES-1:0] w_free;
    logic [LANES-1:0] w_full;
    logic [LANES-1:0] w_load;
    lane_mask_t       w_sel_onehot;
    word_t            w_data [LANES];
    logic             w_bcast;
    logic             w_sel_free;
    logic             w_all_free;
    logic             w_route_ready;
    logic             w_accept;
    logic [15:0]      r_xfer_count;

`ifdef DMUX8WAY16_BCAST_EN
    assign w_bcast = bcast;
`else
    assign w_bcast = 1'b0;
`endif

    // Readiness depends only on lane state, consumer readiness and sel, never on in_valid
    assign w_sel_onehot  = lane_onehot(sel);
    assign w_sel_free    = w_free[sel];
    assign w_all_free    = &w_free;
    assign w_route_ready = w_bcast ? w_all_free : w_sel_free;
    assign in_ready      = ~rst & w_route_ready;
    assign w_accept      = in_valid & in_ready;

    // Load vector: one lane for unicast, every lane for broadcast, none when idle
    always_comb begin
        w_load = '0;
        if (w_accept) begin
            w_load = w_bcast ? {LANES{1'b1}} : w_sel_onehot;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            dmux_lane u_lane (
                .clk         (clk),
                .rst         (rst),
                .load        (w_load[gi]),
                .din         (in),
                .drain_ready (out_ready[gi]),
                .data        (w_data[gi]),
                .full        (w_full[gi]),
                .free        (w_free[gi])
            );
        end
    endgenerate

    // Accepted-word counter; a broadcast counts as a single transfer, wraps silently
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_count <= '0;
        end else if (w_accept) begin
            r_xfer_count <= r_xfer_count + 16'd1;
        end
    end

    assign out_valid  = w_full;
    assign xfer_count = r_xfer_count;

    assign a = w_data[0];
    assign b = w_data[1];
    assign c = w_data[2];
    assign d = w_data[3];
    assign e = w_data[4];
    assign f = w_data[5];
    assign g = w_data[6];
    assign h = w_data[7];

endmodule : dmux8way16_reg
`default_nettype wire

// File: tb/tb_dmux8way16_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmux8way16_reg
//  Purpose  : Scoreboard bench for dmux8way16_reg. Stimulus records every
//             accepted word; a monitor keeps per-lane expected queues, the
//             expected transfer count and expected readiness, and compares
//             them with the DUT each cycle. Broadcast scenarios are built
//             when DMUX8WAY16_BCAST_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmux8way16_reg;

    localparam int NL        = 8;
    localparam int STALL_MAX = 64;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic [15:0] in_w      = '0;
    logic [2:0]  sel       = '0;
    logic        in_valid  = 1'b0;
    logic        bcast     = 1'b0;
    logic [7:0]  out_ready = '0;

    logic        in_ready;
    logic [15:0] a, b, c, d, e, f, g, h;
    logic [7:0]  out_valid;
    logic [15:0] xfer_count;
    logic [15:0] lane_out [NL];

    assign lane_out[0] = a;
    assign lane_out[1] = b;
    assign lane_out[2] = c;
    assign lane_out[3] = d;
    assign lane_out[4] = e;
    assign lane_out[5] = f;
    assign lane_out[6] = g;
    assign lane_out[7] = h;

    dmux8way16_reg dut (
        .clk        (clk),
        .rst        (rst),
`ifdef DMUX8WAY16_BCAST_EN
        .bcast      (bcast),
`endif
        .in         (in_w),
        .sel        (sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .e          (e),
        .f          (f),
        .g          (g),
        .h          (h),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0]  mask;
        logic [15:0] word;
    } acc_t;

    acc_t        acc_q [$];
    logic [15:0] exp_q [NL][$];
    logic [15:0] last_word [NL];
    logic [15:0] exp_count = '0;
    int          n_tests   = 0;
    int          n_fail    = 0;
    logic        last_acc  = 1'b0;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (idx >= 0)
                $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, idx, act, exp, $time);
            else
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: applies recorded accepts, compares, then retires drains
    // ------------------------------------------------------------------
    initial begin : monitor
        acc_t        ent;
        logic        exp_ready;
        logic        all_free;
        logic        prev_pending;
        logic [15:0] prev_in;
        logic [2:0]  prev_sel;
        logic        prev_bcast;
        prev_pending = 1'b0;
        prev_in      = '0;
        prev_sel     = '0;
        prev_bcast   = 1'b0;
        for (int i = 0; i < NL; i++) last_word[i] = '0;
        forever begin
            @(negedge clk);
            while (acc_q.size() > 0) begin
                ent = acc_q.pop_front();
                for (int i = 0; i < NL; i++) begin
                    if (ent.mask[i]) begin
                        exp_q[i].push_back(ent.word);
                        last_word[i] = ent.word;
                    end
                end
                exp_count = exp_count + 16'd1;
            end
            if (rst) begin
                check("in_ready_in_reset", -1, in_ready, 1'b0);
                for (int i = 0; i < NL; i++) begin
                    exp_q[i].delete();
                    last_word[i] = '0;
                end
                exp_count    = '0;
                prev_pending = 1'b0;
            end else begin
                all_free = 1'b1;
                for (int i = 0; i < NL; i++) begin
                    check("out_valid", i, out_valid[i], exp_q[i].size() != 0);
                    check("lane_data", i, lane_out[i], last_word[i]);
                    if (exp_q[i].size() != 0 && !out_ready[i]) all_free = 1'b0;
                end
                check("xfer_count", -1, xfer_count, exp_count);
                if (bcast)
                    exp_ready = all_free;
                else
                    exp_ready = (exp_q[sel].size() == 0) || out_ready[sel];
                check("in_ready", -1, in_ready, exp_ready);
                if (prev_pending)
                    check("producer_hold", -1, {in_valid, bcast, sel, in_w},
                          {1'b1, prev_bcast, prev_sel, prev_in});
                prev_pending = in_valid && !in_ready;
                prev_in      = in_w;
                prev_sel     = sel;
                prev_bcast   = bcast;
                for (int i = 0; i < NL; i++) begin
                    if (out_valid[i] && out_ready[i] && exp_q[i].size() != 0)
                        void'(exp_q[i].pop_front());
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        acc_t ent;
        @(negedge clk);
        last_acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (last_acc) begin
            ent.mask = bcast ? 8'hFF : (8'h01 << sel);
            ent.word = in_w;
            acc_q.push_back(ent);
        end
    endtask

    task automatic wait_accept();
        for (int k = 0; k < STALL_MAX; k++) begin
            step();
            if (last_acc) break;
        end
        in_valid = 1'b0;
        bcast    = 1'b0;
    endtask

    task automatic send(input logic [2:0] s, input logic [15:0] w, input logic bc);
        in_valid = 1'b1;
        sel      = s;
        in_w     = w;
        bcast    = bc;
        wait_accept();
    endtask

    // Offer a word for hold_cycles with current out_ready, then open release_mask
    task automatic hold_then_release(input logic [2:0] s, input logic [15:0] w, input logic bc,
                                     input int hold_cycles, input logic [7:0] release_mask);
        in_valid = 1'b1;
        sel      = s;
        in_w     = w;
        bcast    = bc;
        for (int k = 0; k < hold_cycles; k++) begin
            step();
            if (last_acc) break;
        end
        if (!last_acc) begin
            out_ready = out_ready | release_mask;
            wait_accept();
        end else begin
            in_valid = 1'b0;
            bcast    = 1'b0;
        end
    endtask

    task automatic reset_pulse();
        in_valid = 1'b0;
        bcast    = 1'b0;
        rst      = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    initial begin : stim
        logic [15:0] sweep [8];
        int          accepts;
        sweep = '{16'h5555, 16'hAAAA, 16'h00FF, 16'hFF00,
                  16'h3333, 16'hCCCC, 16'h0F0F, 16'hF0F0};

        // Power-on reset, then idle cycles with varying sel
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel = 3'(i * 3);
            step();
        end

        // Unicast sweep across all lanes with consumers always ready
        out_ready = 8'hFF;
        for (int i = 0; i < 8; i++) send(3'(i), sweep[i], 1'b0);
        step();
        step();

        // Backpressure on lane d, then release with a same-cycle refill
        out_ready = 8'h00;
        send(3'd3, 16'hFF00, 1'b0);
        hold_then_release(3'd3, 16'h1357, 1'b0, 4, 8'h08);
        out_ready = 8'h00;
        step();
        step();
        out_ready = 8'hFF;
        step();
        step();

        // Drain-and-refill on lane f with no bubble
        out_ready = 8'h00;
        send(3'd5, 16'hBEEF, 1'b0);
        out_ready = 8'h20;
        send(3'd5, 16'hCAFE, 1'b0);
        out_ready = 8'h00;
        step();
        out_ready = 8'hFF;
        step();
        step();

        // Reset with words held in several lanes
        out_ready = 8'h00;
        send(3'd1, 16'h1111, 1'b0);
        send(3'd4, 16'h4444, 1'b0);
        send(3'd6, 16'h6666, 1'b0);
        sel = 3'd4;
        reset_pulse();
        step();

`ifdef DMUX8WAY16_BCAST_EN
        // Broadcast blocked by a stalled lane c, then released
        out_ready = 8'h00;
        send(3'd2, 16'hAAAA, 1'b0);
        hold_then_release(3'd0, 16'h1234, 1'b1, 3, 8'h04);
        out_ready = 8'h00;
        step();
        step();
        out_ready = 8'hFF;
        step();
        step();
`endif

        // Randomized traffic with random consumer readiness
        in_valid = 1'b0;
        last_acc = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            out_ready = 8'($urandom);
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                sel      = 3'($urandom_range(0, 7));
                in_w     = 16'($urandom);
`ifdef DMUX8WAY16_BCAST_EN
                bcast    = in_valid && ($urandom_range(0, 7) == 0);
`endif
            end
            step();
        end
        in_valid = 1'b0;
        bcast    = 1'b0;
        out_ready = 8'hFF;
        step();
        step();

        // Counter wrap: 65536 accepts from reset bring xfer_count back to zero
        reset_pulse();
        out_ready = 8'hFF;
        in_valid  = 1'b1;
        sel       = 3'($urandom_range(0, 7));
        in_w      = 16'($urandom);
        accepts   = 0;
        for (int t = 0; t < 66000 && accepts < 65536; t++) begin
            step();
            if (last_acc) begin
                accepts++;
                sel  = 3'($urandom_range(0, 7));
                in_w = 16'($urandom);
            end
        end
        in_valid = 1'b0;
        step();
        send(3'd7, 16'h7777, 1'b0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_dmux8way16_reg
`default_nettype wire
